// File: rtl/gate_vector_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : gate_vector_sweeper
//  Description : Drives every N_IN-bit input combination of a NAND gate in
//                ascending order, holds each for DWELL cycles, samples the
//                gate output at the end of each dwell and counts mismatches.
//                Optional first-failure capture is built when the macro
//                SWEEP_FIRST_FAIL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_vector_sweeper #(
    parameter int N_IN  = 3,
    parameter int DWELL = 10,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_q,
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_vld
);

    // Dwell counter is at least one bit wide so DWELL=1 still synthesises.
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]    C_DWELL_LAST = DW'(DWELL - 1);
    localparam logic [ERR_W-1:0] C_ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_IN-1:0]  r_vec;
    logic [DW-1:0]    r_dwell;
    logic [ERR_W-1:0] r_err;
    logic             r_mismatch;

    logic w_start_go;
    logic w_sample;
    logic w_last_vec;
    logic w_fail;

    // Decode sample edge, expected-NAND comparison and start qualification.
    always_comb begin
        w_start_go = 1'b0;
        w_sample   = 1'b0;
        w_last_vec = 1'b0;
        w_fail     = 1'b0;
        w_start_go = (r_state != S_RUN) && start;
        w_sample   = (r_state == S_RUN) && (r_dwell == C_DWELL_LAST);
        w_last_vec = &r_vec;
        // Gate output is only trusted at the end of the dwell window.
        w_fail     = w_sample && (dut_q != ~(&r_vec));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is honoured only outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_sample && w_last_vec) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sweep datapath: vector/dwell stepping, mismatch pulse, saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec      <= '0;
            r_dwell    <= '0;
            r_err      <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_fail;
            if (w_start_go) begin
                r_vec   <= '0;
                r_dwell <= '0;
                r_err   <= '0;
            end else if (r_state == S_RUN) begin
                if (w_fail && (r_err != C_ERR_MAX)) begin
                    r_err <= r_err + ERR_W'(1);
                end
                if (!w_sample) begin
                    r_dwell <= r_dwell + DW'(1);
                end else if (w_last_vec) begin
                    // Sweep ends on all-ones; park the vector at zero.
                    r_vec   <= '0;
                    r_dwell <= '0;
                end else begin
                    r_vec   <= r_vec + N_IN'(1);
                    r_dwell <= '0;
                end
            end
        end
    end

`ifdef SWEEP_FIRST_FAIL_EN
    logic [N_IN-1:0] r_first_fail;
    logic            r_first_fail_vld;

    // Latch the first failing vector of a sweep; later failures leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_fail     <= '0;
            r_first_fail_vld <= 1'b0;
        end else if (w_start_go) begin
            r_first_fail     <= '0;
            r_first_fail_vld <= 1'b0;
        end else if (w_fail && !r_first_fail_vld) begin
            r_first_fail     <= r_vec;
            r_first_fail_vld <= 1'b1;
        end
    end

    assign first_fail     = r_first_fail;
    assign first_fail_vld = r_first_fail_vld;
`else
    assign first_fail     = '0;
    assign first_fail_vld = 1'b0;
`endif

    assign vec_out  = r_vec;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign pass     = (r_state == S_DONE) && (r_err == '0);
    assign mismatch = r_mismatch;
    assign err_cnt  = r_err;

endmodule
`default_nettype wire
